// File: rtl/out_select_sequencer.sv
// out_select_sequencer
//   Drives the 1-based select code for the downstream output decoder. Code 0
//   means all outputs off. Codes 1..NUM_OUTS are stepped through in one of two
//   ways: automatically, holding each code for a programmable dwell time, or
//   by one code per step pulse. All outputs are registered so that they can
//   feed the decoder directly.
//
//   The default SEL_SIZE is 4 because encoding eight outputs plus the
//   all-off code needs four bits.
//
// Ports
//   clk        in   1            system clock, rising edge
//   rst        in   1            asynchronous reset, active-high
//   start      in   1            one-cycle pulse; begins a sequence from IDLE
//   stop       in   1            one-cycle pulse; aborts to IDLE
//   step_mode  in   1            sampled with start: 0 = auto scan, 1 = manual step
//   step       in   1            advance pulse, honoured only in STEP
//   dwell      in   DWELL_WIDTH  extra cycles each code is held in SCAN
//   sel        out  SEL_SIZE     select code; 0 = none, 1..NUM_OUTS active
//   busy       out  1            high in SCAN or STEP
//   wrap       out  1            one-cycle pulse when sel wraps NUM_OUTS -> 1
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | sel = 0, waiting for start
// SCAN  | auto advance every dwell+1 cycles until stop
// STEP  | advance once per step pulse until stop

module out_select_sequencer #(
    parameter int SEL_SIZE    = 4,
    parameter int NUM_OUTS    = 8,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   step_mode,
    input  logic                   step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [SEL_SIZE-1:0]    sel,
    output logic                   busy,
    output logic                   wrap
);

    if (NUM_OUTS < 1 || NUM_OUTS > (2 ** SEL_SIZE) - 1) begin : g_param_check
        $fatal(1, "out_select_sequencer: NUM_OUTS must be in 1..2**SEL_SIZE-1");
    end

    localparam logic [SEL_SIZE-1:0]    SEL_ONE  = SEL_SIZE'(1);
    localparam logic [SEL_SIZE-1:0]    SEL_LAST = SEL_SIZE'(NUM_OUTS);
    localparam logic [DWELL_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [DWELL_WIDTH-1:0] CNT_ONE  = DWELL_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [DWELL_WIDTH-1:0] cnt, cnt_nxt;
    logic [SEL_SIZE-1:0]    sel_nxt;
    logic                   busy_nxt;
    logic                   wrap_nxt;
    logic                   advance;

    // State register; outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
            sel   <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            busy  <= busy_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Next-state logic. stop is a no-op in IDLE, so start always wins there;
    // start while busy is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = step_mode ? STEP : SCAN;
            SCAN:    if (stop)  state_nxt = IDLE;
            STEP:    if (stop)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next-output logic. The dwell counter is a down-counter: a code advances
    // when it reaches zero, and dwell is re-sampled only on that reload.
    always_comb begin
        sel_nxt  = sel;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        advance  = 1'b0;

        case (state)
            IDLE: begin
                sel_nxt = '0;
                cnt_nxt = CNT_ZERO;
                if (start) begin
                    sel_nxt = SEL_ONE;
                    cnt_nxt = step_mode ? CNT_ZERO : dwell;
                end
            end
            SCAN: begin
                if (stop) begin
                    sel_nxt = '0;
                    cnt_nxt = CNT_ZERO;
                end else if (cnt == CNT_ZERO) begin
                    advance = 1'b1;
                    cnt_nxt = dwell;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            STEP: begin
                if (stop) begin
                    sel_nxt = '0;
                    cnt_nxt = CNT_ZERO;
                end else if (step) begin
                    advance = 1'b1;
                end
            end
            default: begin
                sel_nxt = '0;
                cnt_nxt = CNT_ZERO;
            end
        endcase

        if (advance) begin
            if (sel == SEL_LAST) begin
                sel_nxt  = SEL_ONE;
                wrap_nxt = 1'b1;
            end else begin
                sel_nxt = sel + SEL_ONE;
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_out_select_sequencer.sv
module tb_out_select_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic [7:0] dwell = 8'd0;

    logic [3:0] sel8;
    logic       busy8, wrap8;
    logic [0:0] sel1;
    logic       busy1, wrap1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    out_select_sequencer #(.SEL_SIZE(4), .NUM_OUTS(8), .DWELL_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode),
        .step(step), .dwell(dwell), .sel(sel8), .busy(busy8), .wrap(wrap8)
    );

    out_select_sequencer #(.SEL_SIZE(1), .NUM_OUTS(1), .DWELL_WIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode),
        .step(step), .dwell(dwell), .sel(sel1), .busy(busy1), .wrap(wrap1)
    );

    // Reference model: mode 0 idle, 1 scan, 2 step. age counts cycles the
    // current code has been shown; hold is how many it should be shown.
    typedef struct {
        int mode;
        int pos;
        int age;
        int hold;
        bit wrap;
    } mst_t;

    mst_t m8, m1;

    function automatic mst_t mreset();
        mst_t r;
        r.mode = 0; r.pos = 0; r.age = 0; r.hold = 0; r.wrap = 0;
        return r;
    endfunction

    function automatic mst_t mstep(mst_t s, int n, bit st, bit sp, bit sm, bit stp, int dw);
        mst_t r;
        bit   adv;
        r = s;
        r.wrap = 0;
        if (s.mode == 0) begin
            if (st) begin
                r.mode = sm ? 2 : 1;
                r.pos  = 1;
                r.age  = 1;
                r.hold = dw + 1;
            end
        end else if (sp) begin
            r.mode = 0;
            r.pos  = 0;
        end else begin
            adv = (s.mode == 1) ? (s.age == s.hold) : stp;
            if (s.mode == 1) begin
                if (adv) begin
                    r.age  = 1;
                    r.hold = dw + 1;
                end else begin
                    r.age = s.age + 1;
                end
            end
            if (adv) begin
                r.wrap = (s.pos == n);
                r.pos  = (s.pos == n) ? 1 : s.pos + 1;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check8(input string tag, input int es, input int eb, input int ew);
        check({tag, " sel"},  int'(sel8),  es);
        check({tag, " busy"}, int'(busy8), eb);
        check({tag, " wrap"}, int'(wrap8), ew);
    endtask

    // One clock: advance the models with the inputs seen at this edge, then
    // settle 1 time unit before the caller samples outputs.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m8 = mreset();
            m1 = mreset();
        end else begin
            m8 = mstep(m8, 8, start, stop, step_mode, step, int'(dwell));
            m1 = mstep(m1, 1, start, stop, step_mode, step, int'(dwell));
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 0; stop = 0; step = 0; step_mode = 0; dwell = 0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Invariants on both instances, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("inv sel8 range", int'(sel8 <= 4'd8), 1);
            check("inv sel8 nonzero when busy", int'(!busy8 || sel8 != 0), 1);
            check("inv sel1 nonzero when busy", int'(!busy1 || sel1 != 0), 1);
        end
    end

    typedef struct {
        bit start;
        bit stop;
        bit sm;
        bit step;
        int sel;
        bit busy;
        bit wrap;
    } vec_t;

    function automatic vec_t mk(bit st, bit sp, bit sm, bit stp, int s, bit b, bit w);
        vec_t v;
        v.start = st; v.stop = sp; v.sm = sm; v.step = stp;
        v.sel = s; v.busy = b; v.wrap = w;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        m8 = mreset();
        m1 = mreset();

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0);  // idle
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0);  // stop in idle: no effect
        tbl[2]  = mk(1, 0, 1, 0, 1, 1, 0);  // start manual
        tbl[3]  = mk(0, 0, 0, 1, 2, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 2, 1, 0);  // start mid-STEP ignored
        tbl[5]  = mk(0, 0, 0, 1, 3, 1, 0);  // step held high
        tbl[6]  = mk(0, 0, 0, 1, 4, 1, 0);
        tbl[7]  = mk(0, 0, 0, 1, 5, 1, 0);
        tbl[8]  = mk(0, 0, 0, 1, 6, 1, 0);
        tbl[9]  = mk(0, 0, 0, 1, 7, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 8, 1, 0);
        tbl[11] = mk(0, 0, 0, 1, 1, 1, 1);  // wrap
        tbl[12] = mk(0, 0, 0, 0, 1, 1, 0);
        tbl[13] = mk(1, 1, 0, 1, 0, 0, 0);  // stop beats step and start
        tbl[14] = mk(1, 1, 0, 0, 1, 1, 0);  // start+stop in idle: start wins, SCAN
        tbl[15] = mk(0, 0, 0, 0, 2, 1, 0);
        tbl[16] = mk(0, 0, 0, 1, 3, 1, 0);  // step ignored in SCAN
        tbl[17] = mk(0, 1, 0, 0, 0, 0, 0);

        // Reset values while reset is held.
        rst = 1'b1;
        #2;
        check8("reset", 0, 0, 0);
        do_reset();

        // Table-driven directed vectors.
        for (int i = 0; i < 18; i++) begin
            start = tbl[i].start; stop = tbl[i].stop;
            step_mode = tbl[i].sm; step = tbl[i].step; dwell = 8'd0;
            cycle();
            check8($sformatf("tbl%0d", i), tbl[i].sel, int'(tbl[i].busy), int'(tbl[i].wrap));
        end
        start = 0; stop = 0; step = 0;

        // Auto scan, dwell=2: each code held 3 cycles, wrap in first cycle of 1 after 8.
        do_reset();
        start = 1; step_mode = 0; dwell = 8'd2;
        cycle();
        start = 0;
        for (int k = 0; k < 27; k++) begin
            check8($sformatf("scan2 k%0d", k), (k / 3) % 8 + 1, 1, (k == 24) ? 1 : 0);
            cycle();
        end
        stop = 1;
        cycle();
        stop = 0;
        check8("scan2 stop", 0, 0, 0);

        // Stop coinciding with dwell expiry at sel=8: no wrap pulse.
        start = 1; dwell = 8'd2;
        cycle();
        start = 0;
        for (int k = 0; k < 23; k++) cycle();
        check8("expiry pre", 8, 1, 0);
        stop = 1;
        cycle();
        stop = 0;
        check8("expiry stop", 0, 0, 0);
        cycle();
        check8("expiry after", 0, 0, 0);

        // dwell=0 then dwell=3 mid-code: new hold applies from the next code.
        start = 1; dwell = 8'd0;
        cycle();
        start = 0;
        check8("dw0 a", 1, 1, 0);
        cycle();
        check8("dw0 b", 2, 1, 0);
        cycle();
        check8("dw0 c", 3, 1, 0);
        dwell = 8'd3;
        for (int i = 0; i < 9; i++) begin
            cycle();
            check8($sformatf("dw3 i%0d", i), 4 + i / 4, 1, 0);
        end

        // Reset asserted mid-SCAN with sel=5: outputs clear without a clock edge.
        do_reset();
        start = 1; dwell = 8'd0;
        cycle();
        start = 0;
        for (int i = 0; i < 4; i++) cycle();
        check8("pre-reset", 5, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check8("async reset", 0, 0, 0);
        cycle();
        rst = 1'b0;
        cycle();
        check8("after reset", 0, 0, 0);

        // NUM_OUTS=1, dwell=0: sel stays 1, wrap every cycle after the first.
        start = 1; step_mode = 0; dwell = 8'd0;
        cycle();
        start = 0;
        check("n1 sel first", int'(sel1), 1);
        check("n1 wrap first", int'(wrap1), 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("n1 sel i%0d", i), int'(sel1), 1);
            check($sformatf("n1 wrap i%0d", i), int'(wrap1), 1);
            check($sformatf("n1 busy i%0d", i), int'(busy1), 1);
        end
        stop = 1;
        cycle();
        stop = 0;

        // Randomized stimulus against the reference model, both instances.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 15) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            step      = $urandom_range(0, 1);
            step_mode = $urandom_range(0, 1);
            dwell     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20))
                                                    : 8'($urandom_range(0, 3));
            cycle();
            check("rnd sel8",  int'(sel8),  m8.pos);
            check("rnd busy8", int'(busy8), int'(m8.mode != 0));
            check("rnd wrap8", int'(wrap8), int'(m8.wrap));
            check("rnd sel1",  int'(sel1),  m1.pos);
            check("rnd busy1", int'(busy1), int'(m1.mode != 0));
            check("rnd wrap1", int'(wrap1), int'(m1.wrap));
        end

        start = 0; stop = 0; step = 0;
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
